pipelined_cla_adder: RTL
========================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor: the successor to the 4-bit lookahead adder, generalised to WIDTH bits built from GROUP-bit lookahead groups. Each group is one pipeline stage, so group k registers the carry out of group k-1. The result is one add/sub per cycle at a fixed latency of WIDTH/GROUP cycles. The block sits between an operand source and a result consumer, with valid/ready handshakes and full backpressure on both sides.

## Interface
- WIDTH, 16, operand/sum width; must be an integer multiple of GROUP.
- GROUP, 4, bits per lookahead group (2..8); N = WIDTH/GROUP pipeline stages.
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept an operand set this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- c_in  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+c_in; 1: A-B, computed as A+~B+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- S  output  WIDTH  sum/difference.
- c_out  output  1  carry out of the MSB; in subtract mode, 1 means no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  S == 0.

## Operation
- Stage k (k = 0..N-1) holds:
  - valid bit v[k];
  - registered carry into group k;
  - sum bits of groups 0..k-1, already computed;
  - unprocessed A and B bits of groups k..N-1, with B already inverted when sub=1.
- Stage 0 captures the input transaction:
  - B' = sub ? ~B : B;
  - carry into group 0 = sub ? 1 : c_in.
- Group k logic is the 4-bit lookahead generalised to GROUP bits:
  - p_i = a_i ^ b_i, g_i = a_i & b_i;
  - internal carries c_{i+1} = g_i | (p_i & c_i), flattened to two-level lookahead;
  - group sum bits s_i = p_i ^ c_i;
  - group propagate PG = AND of p_i; group generate GG computed in the same lookahead form.
- Carry out of group k = GG | (PG & carry_in_k). It is registered into stage k+1 together with the accumulated sum bits and the remaining operand bits.
- The last stage's group produces the final S, c_out, and the MSB carry-in used for overflow. These are held in an output register with out_valid.
- Flow control:
  - adv[N] = !out_valid | out_ready;
  - adv[k] = !v[k] | adv[k+1];
  - in_ready = adv[0].
- Stage k loads when adv[k] is high. Its valid bit becomes the upstream valid (in_valid for stage 0).
- When adv[k] is low, stage k holds all contents unchanged.
- Ordering is strict FIFO. No transaction is dropped or duplicated.
- While out_valid is high and out_ready is low, S, c_out, overflow and zero remain stable.

## Timing
- Reset (asynchronous, immediate):
  - all v[k] and out_valid = 0;
  - S = 0, c_out = 0, overflow = 0, zero = 0;
  - in_ready = 1 after Reset deasserts.
- In-flight transactions are discarded on reset. No result appears from pre-reset inputs.
- Latency: a transaction accepted on edge t (in_valid & in_ready) presents out_valid on the cycle after edge t+N. Default: 4 cycles.
- Throughput: one transaction per cycle when out_ready is held high.
- Full pipeline (all N+1 registers valid) with out_ready=0: in_ready = 0 combinationally.
- When out_ready rises, in_ready rises in the same cycle (pass-through ready). Simultaneous accept-in and accept-out is legal.
- in_valid with in_ready=0: the block does not capture. The source must hold its data.
- Combinational path per stage is one GROUP-bit lookahead. There is no ripple across groups within a cycle.

## Test plan
- WIDTH=16, GROUP=4: add 0xFFFF + 0x0001, c_in=0 → S=0x0000, c_out=1, overflow=0, zero=1, out_valid 4 cycles after accept.
- Add 0x1234 + 0x4321, c_in=1 → S=0x5556, c_out=0, overflow=0, zero=0. Repeat with sub=1 and c_in=1 (0x1234 - 0x4321) → S=0xCF13, c_out=0; c_in is ignored.
- Sub 0x8000 - 0x0001 → S=0x7FFF, c_out=1, overflow=1. Sub 0x0005 - 0x0005 → S=0x0000, c_out=1, zero=1.
- Ten back-to-back random transactions with out_ready=1 → ten results on consecutive cycles in order, each matching a reference model. Run 10k random vectors with random in_valid/out_ready toggling against the same model.
- Hold out_ready=0 and stream inputs → exactly 5 transactions accepted (4 stages + output register), then in_ready=0. S stays stable while stalled. Raise out_ready → results drain in order with no loss or duplication.
- Assert Reset mid-cycle with 3 transactions in flight → out_valid and outputs go to 0 before the next edge. After release, no stale result appears and the next input yields the correct result after 4 cycles.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage,
// with valid/ready flow control and an output register, giving WIDTH/GROUP cycles of latency.

module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [GROUP-1:0] p, g, c;
    logic             prod, term, gg, pg;

    // Every carry is a flat sum of generate terms, so there is no ripple inside the group.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        prod = 1'b1;
        term = 1'b0;
        for (int i = 1; i < GROUP; i++) begin
            prod = 1'b1;
            term = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (g[j] & prod);
                prod = prod & p[j];
            end
            c[i] = term | (cin & prod);
        end
        gg   = 1'b0;
        prod = 1'b1;
        for (int j = GROUP - 1; j >= 0; j--) begin
            gg   = gg | (g[j] & prod);
            prod = prod & p[j];
        end
        pg    = &p;
        cout  = gg | (pg & cin);
        s     = p ^ c;
        c_msb = c[GROUP-1];
    end
endmodule

module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);
    localparam int N = WIDTH / GROUP;

    logic [N-1:0]            v_q, v_d, c_q, c_d;
    logic [N-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [N-1:0][GROUP-1:0] gsum;
    logic [N-1:0]            gcout, gcmsb;
    logic [N:0]              adv;
    logic [WIDTH-1:0]        s_fin;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_out_q, s_out_d;
    logic             c_out_q, c_out_d, ovf_q, ovf_d, zero_q, zero_d;

    // Operand bits of the last stage and the MSB carries of inner groups feed nothing further.
    logic unused_bits;
    assign unused_bits = ^{a_q[N-1], b_q[N-1], gcmsb};

    for (genvar k = 0; k < N; k++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .a    (a_q[k][k*GROUP +: GROUP]),
            .b    (b_q[k][k*GROUP +: GROUP]),
            .cin  (c_q[k]),
            .s    (gsum[k]),
            .cout (gcout[k]),
            .c_msb(gcmsb[k])
        );
    end

    always_comb begin
        adv    = '0;
        adv[N] = !out_valid_q | out_ready;
        for (int k = N - 1; k >= 0; k--) begin
            adv[k] = !v_q[k] | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    always_comb begin
        v_d = v_q;
        c_d = c_q;
        a_d = a_q;
        b_d = b_q;
        s_d = s_q;
        if (adv[0]) begin
            v_d[0] = in_valid;
            a_d[0] = A;
            b_d[0] = sub ? ~B : B;
            c_d[0] = sub | c_in;
            s_d[0] = '0;
        end
        for (int k = 1; k < N; k++) begin
            if (adv[k]) begin
                v_d[k] = v_q[k-1];
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
                c_d[k] = gcout[k-1];
                s_d[k] = s_q[k-1];
                s_d[k][(k-1)*GROUP +: GROUP] = gsum[k-1];
            end
        end
    end

    // Result data only moves on a real transaction, so bubbles never disturb S.
    always_comb begin
        s_fin = s_q[N-1];
        s_fin[(N-1)*GROUP +: GROUP] = gsum[N-1];
        out_valid_d = out_valid_q;
        s_out_d     = s_out_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (adv[N]) begin
            out_valid_d = v_q[N-1];
            if (v_q[N-1]) begin
                s_out_d = s_fin;
                c_out_d = gcout[N-1];
                ovf_d   = gcout[N-1] ^ gcmsb[N-1];
                zero_d  = (s_fin == '0);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v_q         <= '0;
            c_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
            s_out_q     <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            v_q         <= v_d;
            c_q         <= c_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            s_out_q     <= s_out_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_out_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
endmodule
